// File: rtl/pe_credit_gen_sink_if.sv
// ---------------------------------------------------------------------------
// pe_credit_gen_sink_if
// Bundles every non-clock/reset signal between a NoC router local port (plus
// the PE control inputs) and pe_credit_gen_sink.
//   master : the processing element side (pe_credit_gen_sink itself)
//   slave  : the router / environment side
// Signals
//   gen_en      allow generator to start new packets
//   dest_id     destination for next packet, taken when a head is emitted
//   datain      incoming flit from router
//   in_valid    datain valid this cycle
//   ci          credit return, one credit per cycle high
//   dataout     outgoing flit (registered)
//   out_valid   dataout valid this cycle (registered)
//   credit_cnt  credits currently available
//   read        datain[15:0] of the last accepted RX flit
//   rx_pkt_cnt  good tails received, saturating
//   rx_err      sticky RX framing/destination error
//   cr_err      sticky credit overflow error
// ---------------------------------------------------------------------------
interface pe_credit_gen_sink_if #(
    parameter int FLIT_W = 20,
    parameter int ID_W   = 4
);
    logic              gen_en;
    logic [ID_W-1:0]   dest_id;
    logic [FLIT_W-1:0] datain;
    logic              in_valid;
    logic              ci;
    logic [FLIT_W-1:0] dataout;
    logic              out_valid;
    logic [7:0]        credit_cnt;
    logic [15:0]       read;
    logic [15:0]       rx_pkt_cnt;
    logic              rx_err;
    logic              cr_err;

    modport master (
        input  gen_en, dest_id, datain, in_valid, ci,
        output dataout, out_valid, credit_cnt, read, rx_pkt_cnt, rx_err, cr_err
    );

    modport slave (
        output gen_en, dest_id, datain, in_valid, ci,
        input  dataout, out_valid, credit_cnt, read, rx_pkt_cnt, rx_err, cr_err
    );
endinterface

// File: rtl/pe_credit_gen_sink.sv
// ---------------------------------------------------------------------------
// pe_credit_gen_sink
// NoC processing element with credit-based output flow control.
//   TX: packet generator emitting head/body/tail flits toward the router,
//       one flit per cycle whenever a downstream credit is available.
//   RX: sink checking incoming packet framing and destination.
// Ports
//   clk   clock, rising edge
//   rst   synchronous reset, active-high
//   bus   pe_credit_gen_sink_if.master (see interface header for signals)
// Flit format: [FLIT_W-1:FLIT_W-2] type (01 head, 00 body, 10 tail,
// 11 reserved), remaining bits payload.
//   head payload : {dest, NODE_ID, packet sequence}
//   body/tail    : running flit counter (counts every flit sent, heads
//                  included, so payloads show gaps where heads went out)
// ---------------------------------------------------------------------------
module pe_credit_gen_sink #(
    parameter int FLIT_W  = 20,
    parameter int ID_W    = 4,
    parameter int NODE_ID = 6,
    parameter int CREDITS = 7,
    parameter int PKT_LEN = 4,
    parameter int GAP     = 0
) (
    input logic                  clk,
    input logic                  rst,
    pe_credit_gen_sink_if.master bus
);

    localparam int PAY_W    = FLIT_W - 2;
    localparam int SEQ_W    = FLIT_W - 2 - 2 * ID_W;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [1:0]      TY_BODY = 2'b00;
    localparam logic [1:0]      TY_HEAD = 2'b01;
    localparam logic [1:0]      TY_TAIL = 2'b10;
    localparam logic [ID_W-1:0] NODE_ID_L = ID_W'(NODE_ID);
    localparam logic [7:0]      CREDITS_L = 8'(CREDITS);
    localparam logic [7:0]      BODY_LAST = 8'(PKT_LEN - 2);
    localparam logic [7:0]      GAP_LAST_L = 8'(GAP_LAST);

    typedef enum logic [1:0] {T_IDLE, T_HEAD, T_BODY, T_GAP} tx_state_t;
    typedef enum logic {R_IDLE, R_BODY} rx_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tx_state_t          tx_state_reg, tx_state_next;
    rx_state_t          rx_state_reg, rx_state_next;
    logic [7:0]         body_cnt_reg, body_cnt_next;
    logic [7:0]         gap_cnt_reg, gap_cnt_next;
    logic [7:0]         credit_cnt_reg, credit_cnt_next;
    logic [SEQ_W-1:0]   seq_reg;
    logic [PAY_W-1:0]   flit_cnt_reg;
    logic [FLIT_W-1:0]  dataout_reg;
    logic               out_valid_reg;
    logic [15:0]        read_reg;
    logic [15:0]        rx_pkt_cnt_reg;
    logic               rx_err_reg;
    logic               cr_err_reg;

    logic               send;
    logic               head_sent;
    logic [FLIT_W-1:0]  tx_flit;
    logic               have_credit;
    logic               credit_ovf;
    logic               rx_bad;
    logic               rx_good_tail;
    logic [1:0]         rx_type;
    logic [ID_W-1:0]    rx_dest;
    logic [15:0]        read_next;

    assign have_credit = (credit_cnt_reg != 8'd0);
    assign rx_type     = bus.datain[FLIT_W-1 -: 2];
    assign rx_dest     = bus.datain[FLIT_W-3 -: ID_W];

    // read mirrors datain[15:0]; bits above FLIT_W (narrow flits) read as 0.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_read_bits
            if (gi < FLIT_W) begin : g_bit
                assign read_next[gi] = bus.datain[gi];
            end else begin : g_zero
                assign read_next[gi] = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // TX FSM: next state and flit selection
    // ------------------------------------------------------------------
    always_comb begin
        tx_state_next = tx_state_reg;
        body_cnt_next = body_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        send          = 1'b0;
        head_sent     = 1'b0;
        tx_flit       = dataout_reg;   // dataout holds when nothing is sent
        case (tx_state_reg)
            T_IDLE: begin
                if (bus.gen_en) begin
                    tx_state_next = T_HEAD;
                end
            end
            T_HEAD: begin
                if (have_credit) begin
                    send          = 1'b1;
                    head_sent     = 1'b1;
                    tx_flit       = {TY_HEAD, bus.dest_id, NODE_ID_L, seq_reg};
                    body_cnt_next = 8'd0;
                    tx_state_next = T_BODY;
                end
            end
            T_BODY: begin
                if (have_credit) begin
                    send = 1'b1;
                    if (body_cnt_reg == BODY_LAST) begin
                        tx_flit = {TY_TAIL, flit_cnt_reg};
                        if (GAP > 0) begin
                            gap_cnt_next  = 8'd0;
                            tx_state_next = T_GAP;
                        end else begin
                            tx_state_next = bus.gen_en ? T_HEAD : T_IDLE;
                        end
                    end else begin
                        tx_flit       = {TY_BODY, flit_cnt_reg};
                        body_cnt_next = body_cnt_reg + 8'd1;
                    end
                end
            end
            T_GAP: begin
                if (gap_cnt_reg == GAP_LAST_L) begin
                    tx_state_next = bus.gen_en ? T_HEAD : T_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'd1;
                end
            end
            default: tx_state_next = T_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Credit accounting. A returned credit while already full is dropped
    // and flagged; sending and receiving in the same cycle cancel out.
    // ------------------------------------------------------------------
    always_comb begin
        credit_cnt_next = credit_cnt_reg;
        credit_ovf      = 1'b0;
        if (bus.ci && !send) begin
            if (credit_cnt_reg == CREDITS_L) begin
                credit_ovf = 1'b1;
            end else begin
                credit_cnt_next = credit_cnt_reg + 8'd1;
            end
        end else if (!bus.ci && send) begin
            credit_cnt_next = credit_cnt_reg - 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM: framing and destination check, acts only on valid flits
    // ------------------------------------------------------------------
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_bad        = 1'b0;
        rx_good_tail  = 1'b0;
        if (bus.in_valid) begin
            case (rx_state_reg)
                R_IDLE: begin
                    if (rx_type == TY_HEAD && rx_dest == NODE_ID_L) begin
                        rx_state_next = R_BODY;
                    end else begin
                        rx_bad = 1'b1;
                    end
                end
                R_BODY: begin
                    if (rx_type == TY_BODY) begin
                        rx_state_next = R_BODY;
                    end else if (rx_type == TY_TAIL) begin
                        rx_good_tail  = 1'b1;
                        rx_state_next = R_IDLE;
                    end else begin
                        rx_bad        = 1'b1;
                        rx_state_next = R_IDLE;
                    end
                end
                default: rx_state_next = R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg   <= T_IDLE;
            rx_state_reg   <= R_IDLE;
            body_cnt_reg   <= 8'd0;
            gap_cnt_reg    <= 8'd0;
            credit_cnt_reg <= CREDITS_L;
            seq_reg        <= '0;
            flit_cnt_reg   <= '0;
            dataout_reg    <= '0;
            out_valid_reg  <= 1'b0;
            read_reg       <= 16'd0;
            rx_pkt_cnt_reg <= 16'd0;
            rx_err_reg     <= 1'b0;
            cr_err_reg     <= 1'b0;
        end else begin
            tx_state_reg   <= tx_state_next;
            rx_state_reg   <= rx_state_next;
            body_cnt_reg   <= body_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            credit_cnt_reg <= credit_cnt_next;
            dataout_reg    <= tx_flit;
            out_valid_reg  <= send;
            if (send) begin
                flit_cnt_reg <= flit_cnt_reg + 1'b1;
            end
            if (head_sent) begin
                seq_reg <= seq_reg + 1'b1;
            end
            if (credit_ovf) begin
                cr_err_reg <= 1'b1;
            end
            if (bus.in_valid) begin
                read_reg <= read_next;
            end
            if (rx_bad) begin
                rx_err_reg <= 1'b1;
            end
            if (rx_good_tail && rx_pkt_cnt_reg != 16'hFFFF) begin
                rx_pkt_cnt_reg <= rx_pkt_cnt_reg + 16'd1;
            end
        end
    end

    assign bus.dataout    = dataout_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.credit_cnt = credit_cnt_reg;
    assign bus.read       = read_reg;
    assign bus.rx_pkt_cnt = rx_pkt_cnt_reg;
    assign bus.rx_err     = rx_err_reg;
    assign bus.cr_err     = cr_err_reg;

endmodule
